// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter: unit-select codes, FSM states,
// function-code field widths and the unit-select to enable decoder.
package alu_ctrl_pkg;

  localparam int FUN_WIDTH      = 4;
  localparam int UNIT_SEL_WIDTH = 2;
  localparam int UNIT_FUN_WIDTH = 2;
  localparam int NUM_UNITS      = 4;

  typedef logic [UNIT_SEL_WIDTH-1:0] unit_sel_t;

  localparam unit_sel_t UNIT_ARITH = 2'b00;
  localparam unit_sel_t UNIT_LOGIC = 2'b01;
  localparam unit_sel_t UNIT_CMP   = 2'b10;
  localparam unit_sel_t UNIT_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  // Enable vector bit order: [0] arith, [1] logic, [2] cmp, [3] shift.
  function automatic logic [NUM_UNITS-1:0] unit_enable(input unit_sel_t sel);
    logic [NUM_UNITS-1:0] en;
    en = '0;
    case (sel)
      UNIT_ARITH: en[0] = 1'b1;
      UNIT_LOGIC: en[1] = 1'b1;
      UNIT_CMP:   en[2] = 1'b1;
      UNIT_SHIFT: en[3] = 1'b1;
      default:    en    = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational grant picker: first set request at or after ptr, circularly.
// With ALU_ARB_FIXED_PRIORITY_EN defined, the lowest set index wins and ptr is ignored.
module rr_arb_pick #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 found
);

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  logic ptr_unused;
  assign ptr_unused = ^ptr;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_WIDTH'(i);
        found = 1'b1;
      end
    end
    if (found) gnt[idx] = 1'b1;
  end
`else
  // cand[k] is the requester index k places after the pointer, wrapped.
  logic [IDX_WIDTH-1:0] cand [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_WIDTH:0] sum;
    assign sum = {1'b0, ptr} + (IDX_WIDTH+1)'(gi);
    assign cand[gi] = (sum >= (IDX_WIDTH+1)'(NUM_REQ))
                      ? IDX_WIDTH'(sum - (IDX_WIDTH+1)'(NUM_REQ))
                      : sum[IDX_WIDTH-1:0];
  end

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        idx   = cand[k];
        found = 1'b1;
      end
    end
    if (found) gnt[idx] = 1'b1;
  end
`endif

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one four-unit ALU between NUM_REQ requesters: grant, issue, wait, respond.
// Optional macro ALU_ARB_FIXED_PRIORITY_EN selects fixed lowest-index priority.
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int OPD_WIDTH      = 16,
  parameter int RES_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           REQ,
  input  logic [NUM_REQ*OPD_WIDTH-1:0] REQ_A,
  input  logic [NUM_REQ*OPD_WIDTH-1:0] REQ_B,
  input  logic [NUM_REQ*FUN_WIDTH-1:0] REQ_FUN,
  output logic [NUM_REQ-1:0]           GNT,
  output logic signed [OPD_WIDTH-1:0]  ALU_A,
  output logic signed [OPD_WIDTH-1:0]  ALU_B,
  output logic [UNIT_FUN_WIDTH-1:0]    ALU_FUN,
  output logic                         ARITH_Enable,
  output logic                         LOGIC_Enable,
  output logic                         CMP_Enable,
  output logic                         SHIFT_Enable,
  input  logic [RES_WIDTH-1:0]         ALU_OUT,
  input  logic                         ALU_OUT_VALID,
  output logic [NUM_REQ-1:0]           RSP_VALID,
  output logic [RES_WIDTH-1:0]         RSP_DATA,
  output logic                         RSP_ERR
);

  localparam int IDX_WIDTH = $clog2(NUM_REQ);
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

  logic signed [OPD_WIDTH-1:0] req_a_arr   [NUM_REQ];
  logic signed [OPD_WIDTH-1:0] req_b_arr   [NUM_REQ];
  logic [FUN_WIDTH-1:0]        req_fun_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_a_arr[gi]   = REQ_A[gi*OPD_WIDTH +: OPD_WIDTH];
    assign req_b_arr[gi]   = REQ_B[gi*OPD_WIDTH +: OPD_WIDTH];
    assign req_fun_arr[gi] = REQ_FUN[gi*FUN_WIDTH +: FUN_WIDTH];
  end

  arb_state_t                  state_reg, state_next;
  logic [NUM_REQ-1:0]          gnt_reg, gnt_next;
  logic [IDX_WIDTH-1:0]        idx_reg, idx_next;
  logic [IDX_WIDTH-1:0]        ptr_reg, ptr_next;
  logic signed [OPD_WIDTH-1:0] a_reg, a_next;
  logic signed [OPD_WIDTH-1:0] b_reg, b_next;
  logic [UNIT_FUN_WIDTH-1:0]   fun_reg, fun_next;
  logic [NUM_UNITS-1:0]        en_reg, en_next;
  logic [NUM_REQ-1:0]          rsp_valid_reg, rsp_valid_next;
  logic [RES_WIDTH-1:0]        rsp_data_reg, rsp_data_next;
  logic                        rsp_err_reg, rsp_err_next;
  logic [CNT_WIDTH-1:0]        cnt_reg, cnt_next;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_WIDTH-1:0] pick_idx;
  logic                 pick_found;
  logic [FUN_WIDTH-1:0] pick_fun;

  rr_arb_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req   (REQ),
    .ptr   (ptr_reg),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign pick_fun = req_fun_arr[pick_idx];

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  logic idx_unused;
  assign idx_unused = ^idx_reg;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      idx_reg       <= '0;
      ptr_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      fun_reg       <= '0;
      en_reg        <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      idx_reg       <= idx_next;
      ptr_reg       <= ptr_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      fun_reg       <= fun_next;
      en_reg        <= en_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
      cnt_reg       <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    idx_next       = idx_reg;
    ptr_next       = ptr_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    fun_next       = fun_reg;
    en_next        = en_reg;
    rsp_valid_next = '0;
    rsp_data_next  = rsp_data_reg;
    rsp_err_next   = rsp_err_reg;
    cnt_next       = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          gnt_next   = pick_gnt;
          idx_next   = pick_idx;
          a_next     = req_a_arr[pick_idx];
          b_next     = req_b_arr[pick_idx];
          fun_next   = pick_fun[UNIT_FUN_WIDTH-1:0];
          en_next    = unit_enable(pick_fun[FUN_WIDTH-1 -: UNIT_SEL_WIDTH]);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // Response outputs are registered, so they are loaded on the way into RESP.
        if (ALU_OUT_VALID) begin
          rsp_data_next  = ALU_OUT;
          rsp_err_next   = 1'b0;
          rsp_valid_next = gnt_reg;
          gnt_next       = '0;
          en_next        = '0;
          fun_next       = '0;
          state_next     = RESP;
        end else if (cnt_reg == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_next  = '0;
          rsp_err_next   = 1'b1;
          rsp_valid_next = gnt_reg;
          gnt_next       = '0;
          en_next        = '0;
          fun_next       = '0;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_reg + CNT_WIDTH'(1);
        end
      end
      RESP: begin
`ifndef ALU_ARB_FIXED_PRIORITY_EN
        ptr_next = (idx_reg == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : idx_reg + IDX_WIDTH'(1);
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign GNT          = gnt_reg;
  assign ALU_A        = a_reg;
  assign ALU_B        = b_reg;
  assign ALU_FUN      = fun_reg;
  assign ARITH_Enable = en_reg[0];
  assign LOGIC_Enable = en_reg[1];
  assign CMP_Enable   = en_reg[2];
  assign SHIFT_Enable = en_reg[3];
  assign RSP_VALID    = rsp_valid_reg;
  assign RSP_DATA     = rsp_data_reg;
  assign RSP_ERR      = rsp_err_reg;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: a behavioural ALU answers the enables, a
// round-based reference model predicts grant order and responses.
`timescale 1ns/1ps
module tb_alu_req_arbiter;

  localparam int N  = 4;
  localparam int OW = 16;
  localparam int RW = 32;
  localparam int TO = 15;
  localparam logic signed [OW-1:0] STALL_A = 16'sh7ABC;

  typedef struct {
    int                 idx;
    logic signed [OW-1:0] a;
    logic signed [OW-1:0] b;
    logic [3:0]         fun;
    logic [RW-1:0]      data;
    logic               err;
    bit                 b2b;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  logic [N-1:0] req;
  logic signed [OW-1:0] op_a [N];
  logic signed [OW-1:0] op_b [N];
  logic [3:0] op_fun [N];
  logic [N*OW-1:0] req_a_flat, req_b_flat;
  logic [N*4-1:0]  req_fun_flat;

  logic [N-1:0] gnt;
  logic signed [OW-1:0] alu_a, alu_b;
  logic [1:0] alu_fun;
  logic arith_en, logic_en, cmp_en, shift_en;
  logic [3:0] en;
  logic [RW-1:0] alu_out;
  logic alu_valid;
  logic [N-1:0] rsp_valid;
  logic [RW-1:0] rsp_data;
  logic rsp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rr_ptr   = 0;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always_comb begin
    req_a_flat   = '0;
    req_b_flat   = '0;
    req_fun_flat = '0;
    for (int i = 0; i < N; i++) begin
      req_a_flat[i*OW +: OW]  = op_a[i];
      req_b_flat[i*OW +: OW]  = op_b[i];
      req_fun_flat[i*4 +: 4]  = op_fun[i];
    end
  end

  assign en = {shift_en, cmp_en, logic_en, arith_en};

  alu_req_arbiter #(
    .NUM_REQ(N), .OPD_WIDTH(OW), .RES_WIDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(req),
    .REQ_A(req_a_flat), .REQ_B(req_b_flat), .REQ_FUN(req_fun_flat),
    .GNT(gnt), .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun),
    .ARITH_Enable(arith_en), .LOGIC_Enable(logic_en),
    .CMP_Enable(cmp_en), .SHIFT_Enable(shift_en),
    .ALU_OUT(alu_out), .ALU_OUT_VALID(alu_valid),
    .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err)
  );

  function automatic logic [RW-1:0] ref_alu(input logic [3:0] fun,
                                            input logic signed [OW-1:0] a,
                                            input logic signed [OW-1:0] b);
    int sa, sb, r;
    sa = a;
    sb = b;
    case (fun)
      4'h0: r = sa + sb;
      4'h1: r = sa - sb;
      4'h2: r = sa * sb;
      4'h3: r = sb - sa;
      4'h4: r = sa & sb;
      4'h5: r = sa | sb;
      4'h6: r = sa ^ sb;
      4'h7: r = ~(sa & sb);
      4'h8: r = 0;
      4'h9: r = (sa == sb) ? 1 : 0;
      4'hA: r = (sa > sb) ? 2 : 0;
      4'hB: r = (sa < sb) ? 3 : 0;
      4'hC: r = sa >>> 1;
      4'hD: r = sa <<< 1;
      4'hE: r = sb >>> 1;
      default: r = sb <<< 1;
    endcase
    return RW'(r);
  endfunction

  // Behavioural ALU: one registered stage; never answers when A equals STALL_A.
  always @(posedge CLK) begin
    if (RST) begin
      alu_valid <= 1'b0;
      alu_out   <= '0;
    end else if (en != 4'b0 && alu_a != STALL_A) begin
      alu_valid <= 1'b1;
      case (en)
        4'b0001: alu_out <= ref_alu({2'b00, alu_fun}, alu_a, alu_b);
        4'b0010: alu_out <= ref_alu({2'b01, alu_fun}, alu_a, alu_b);
        4'b0100: alu_out <= ref_alu({2'b10, alu_fun}, alu_a, alu_b);
        default: alu_out <= ref_alu({2'b11, alu_fun}, alu_a, alu_b);
      endcase
    end else begin
      alu_valid <= 1'b0;
    end
  end

  task automatic fail_line(input string name, input logic [63:0] act, input logic [63:0] req_v);
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req_v, cyc);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    n_checks++;
    if (act !== req_v) fail_line(name, act, req_v);
  endtask

  // Reference model: all requests of a round are held together, so service order
  // is the circular order from the pointer (or ascending index in fixed mode).
  task automatic push_round(input logic [N-1:0] mask);
    bit first;
    int last;
    int i;
    first = 1'b1;
    last  = -1;
    for (int k = 0; k < N; k++) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      i = k;
`else
      i = (rr_ptr + k) % N;
`endif
      if (mask[i]) begin
        exp_t e;
        e.idx  = i;
        e.a    = op_a[i];
        e.b    = op_b[i];
        e.fun  = op_fun[i];
        e.err  = (op_a[i] == STALL_A);
        e.data = e.err ? '0 : ref_alu(op_fun[i], op_a[i], op_b[i]);
        e.b2b  = !first;
        first  = 1'b0;
        exp_q.push_back(e);
        last = i;
      end
    end
`ifndef ALU_ARB_FIXED_PRIORITY_EN
    if (last >= 0) rr_ptr = (last + 1) % N;
`endif
  endtask

  task automatic run_round(input logic [N-1:0] mask, input logic [N-1:0] drop);
    logic [N-1:0] served;
    int budget;
    push_round(mask);
    req    = mask;
    served = '0;
    budget = 300;
    while (served != mask && budget > 0) begin
      @(posedge CLK); #1;
      served |= rsp_valid;
      req    &= ~rsp_valid;
      req    &= ~(gnt & drop);
      budget--;
    end
    if (served != mask) begin
      n_checks++;
      fail_line("round_timeout", 64'(served), 64'(mask));
      exp_q.delete();
    end
    req = '0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic rand_op(input int i, input bit allow_stall);
    op_a[i]   = OW'($urandom);
    if (op_a[i] == STALL_A) op_a[i] = op_a[i] ^ 16'sd1;
    op_b[i]   = OW'($urandom);
    op_fun[i] = 4'($urandom_range(0, 15));
    if (allow_stall && $urandom_range(0, 9) == 0) op_a[i] = STALL_A;
  endtask

  // Monitor: checks issue on each new grant and pops the scoreboard on each response.
  initial begin
    exp_t e;
    logic [N-1:0] eg;
    bit gnt_seen;
    int gnt_cyc, last_rsp_cyc;
    gnt_seen     = 1'b0;
    gnt_cyc      = 0;
    last_rsp_cyc = -100;
    forever begin
      @(negedge CLK);
      if (RST !== 1'b0) begin
        gnt_seen = 1'b0;
        continue;
      end
      if (gnt != '0 && !gnt_seen) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          fail_line("unexpected_gnt", 64'(gnt), 64'(0));
        end else begin
          e  = exp_q[0];
          eg = '0;
          eg[e.idx] = 1'b1;
          check("gnt", 64'(gnt), 64'(eg));
          check("unit_enable", 64'(en), 64'(4'b0001 << e.fun[3:2]));
          check("alu_fun", 64'(alu_fun), 64'(e.fun[1:0]));
          check("alu_a", 64'(alu_a), 64'(e.a));
          check("alu_b", 64'(alu_b), 64'(e.b));
          if (e.b2b) check("b2b_spacing", 64'(cyc - last_rsp_cyc), 64'(2));
        end
        gnt_cyc = cyc;
      end
      gnt_seen = (gnt != '0);
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          fail_line("unexpected_rsp", 64'(rsp_valid), 64'(0));
        end else begin
          e  = exp_q.pop_front();
          eg = '0;
          eg[e.idx] = 1'b1;
          check("rsp_valid", 64'(rsp_valid), 64'(eg));
          check("rsp_data", 64'(rsp_data), 64'(e.data));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_latency", 64'(cyc - gnt_cyc), 64'(e.err ? TO + 1 : 2));
          check("enables_in_resp", 64'(en), 64'(0));
        end
        last_rsp_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    n_checks++;
    fail_line("watchdog", 64'(cyc), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;
    logic [N-1:0] mask;
    RST = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_fun[i] = '0;
    end
    repeat (3) @(posedge CLK);
    #1;
    check("reset_gnt", 64'(gnt), 64'(0));
    check("reset_en", 64'(en), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_data", 64'(rsp_data), 64'(0));
    check("reset_rsp_err", 64'(rsp_err), 64'(0));
    check("reset_alu_a", 64'(alu_a), 64'(0));
    RST = 1'b0;
    @(posedge CLK); #1;

    // All four at once: grants 0,1,2,3 (round-robin) from pointer 0.
    for (int i = 0; i < N; i++) rand_op(i, 1'b0);
    run_round(4'b1111, 4'b0000);

    op_a[0] = 16'sd5; op_b[0] = -16'sd3; op_fun[0] = 4'b0000;
    run_round(4'b0001, 4'b0000);

    op_a[1] = -16'sd2; op_b[1] = -16'sd7; op_fun[1] = 4'b1010;
    run_round(4'b0010, 4'b0000);

    op_a[3] = STALL_A; op_b[3] = 16'sd9; op_fun[3] = 4'b0001;
    run_round(4'b1000, 4'b0000);
    rand_op(0, 1'b0);
    run_round(4'b0001, 4'b0000);

    rand_op(2, 1'b0);
    run_round(4'b0100, 4'b0100);

    // Reset while waiting on a stalled unit: no response, pointer back to 0.
    rand_op(1, 1'b0);
    run_round(4'b0010, 4'b0000);
    op_a[2] = STALL_A; op_b[2] = 16'sd1; op_fun[2] = 4'b0000;
    push_round(4'b0100);
    req = 4'b0100;
    budget = 20;
    while (gnt == '0 && budget > 0) begin
      @(posedge CLK); #1;
      budget--;
    end
    check("rst_test_granted", 64'(gnt), 64'(4'b0100));
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    req = '0;
    @(posedge CLK); #1;
    check("midrst_gnt", 64'(gnt), 64'(0));
    check("midrst_en", 64'(en), 64'(0));
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst_alu_fun", 64'(alu_fun), 64'(0));
    RST = 1'b0;
    exp_q.delete();
    rr_ptr = 0;
    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) rand_op(i, 1'b0);
    run_round(4'b1111, 4'b0000);

    for (int r = 0; r < 60; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) rand_op(i, 1'b1);
      run_round(mask, 4'b0000);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one signed structural ALU between NUM_REQ requesters. The ALU has four registered units: arithmetic, logic, compare and shift.
- Arbitrates between requesters round-robin and drives the ALU operands, ALU_FUN and exactly one unit enable.
- Holds the enable until the unit reports a valid result, then returns the result to the granted requester.
- Sits between the requester-side datapath and the ALU top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- OPD_WIDTH, 16, signed operand width driven to the ALU.
- RES_WIDTH, 32, ALU result width returned to requesters.
- TIMEOUT_CYCLES, 15, maximum WAIT cycles before an error response.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous active-high reset.
- REQ  input  NUM_REQ  per-requester request level.
- REQ_A  input  NUM_REQ*OPD_WIDTH  flattened operand A; slice i belongs to requester i.
- REQ_B  input  NUM_REQ*OPD_WIDTH  flattened operand B.
- REQ_FUN  input  NUM_REQ*4  flattened function code; [3:2] selects the unit, [1:0] is the unit ALU_FUN.
- GNT  output  NUM_REQ  one-hot grant.
- ALU_A  output  OPD_WIDTH  registered operand A.
- ALU_B  output  OPD_WIDTH  registered operand B.
- ALU_FUN  output  2  registered unit function.
- ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable  output  1 each  unit enables (at most one high).
- ALU_OUT  input  RES_WIDTH  result from the enabled unit.
- ALU_OUT_VALID  input  1  OR of the unit flags.
- RSP_VALID  output  NUM_REQ  one-cycle response pulse to the granted requester.
- RSP_DATA  output  RES_WIDTH  captured result.
- RSP_ERR  output  1  qualifies RSP_VALID; high means timeout.

Behaviour:
- Reset: CLK and RST only. Reset is synchronous and active-high.
  - All outputs go to 0 and the state goes to IDLE.
  - The round-robin pointer goes to 0 and the timeout counter to 0.
  - Reset mid-operation aborts it with no response pulse.
- State IDLE:
  - With no REQ bit set, stay in IDLE.
  - Otherwise grant the first set REQ bit at or after the pointer, searching circularly.
  - Register that requester's A, B and FUN[1:0] onto ALU_A, ALU_B and ALU_FUN, and set GNT.
  - Raise the enable decoded from FUN[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift.
  - Go to ISSUE.
- State ISSUE: keep the enable and operands stable for one cycle (the unit registers here), then go to WAIT with the counter cleared.
- State WAIT:
  - Enable and operands stay held.
  - If ALU_OUT_VALID=1: capture ALU_OUT into RSP_DATA, set RSP_ERR=0, go to RESP.
  - Else if the counter equals TIMEOUT_CYCLES-1: set RSP_DATA=0 and RSP_ERR=1, go to RESP.
  - Otherwise increment the counter.
- State RESP:
  - RSP_VALID[granted]=1 for exactly this cycle.
  - All enables, GNT and ALU_FUN go to 0. RSP_DATA and RSP_ERR hold until the next response.
  - Pointer becomes granted+1, wrapping modulo NUM_REQ.
  - Go to IDLE.
- Nominal latency: request seen in IDLE at cycle 0, RSP_VALID at cycle 3. Back-to-back grants are spaced at 4 cycles.
- Requester contract: hold REQ and operands until RSP_VALID; drop REQ on or after the pulse.
  - Changes to REQ or operands while granted are ignored.
  - If REQ drops mid-operation, the operation still completes and still pulses RSP_VALID.
- Simultaneous REQ bits: only one grant; the others wait. Round-robin prevents starvation: maximum wait is NUM_REQ-1 services.
- A REQ still asserted in the RESP cycle by the just-served requester is treated as a new request and loses priority to the others.
- Operands pass through unmodified as signed; no width conversion.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins; the pointer is neither used nor updated.
- Undefined: round-robin as above.

Decomposition:
- Package alu_ctrl_pkg holds:
  - unit-select codes UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11;
  - the state enum IDLE/ISSUE/WAIT/RESP;
  - the function-code field widths.
- One sub-module: rr_arb_pick. It is combinational and takes REQ plus the pointer, returning the one-hot grant and index. It contains the fixed-priority variant under the macro.

Test Plan:
- REQ=0001, A=5, B=-3, FUN=4'b0000: CMP_Enable=0, ARITH_Enable=1 on cycles 1-2, ALU_OUT_VALID at cycle 2 with ALU_OUT=2, RSP_VALID=0001 at cycle 3, RSP_DATA=2, RSP_ERR=0.
- REQ=1111 held and answered each time: grants in order 0001, 0010, 0100, 1000, 0001 at 4-cycle spacing. With the macro defined, 0001 repeats.
- FUN=4'b1010 (cmp, A>B), A=-2, B=-7: CMP_Enable only, ALU_FUN=2'b10; bench returns 2, RSP_DATA=2.
- ALU_OUT_VALID held 0: RSP_VALID at cycle 2+TIMEOUT_CYCLES (17) with RSP_ERR=1, RSP_DATA=0; next request proceeds normally.
- RST=1 in WAIT: next cycle all enables, GNT and RSP_VALID are 0 and state is IDLE; no response pulse; pointer back to 0.
- REQ[2] dropped during ISSUE: RSP_VALID=0100 still pulses with a valid result.
